// File: rtl/uart_rx_if.sv
// Serial line in and byte/status handshake out of the uart_rx receiver.
// The receiver takes the master modport; the consumer (or a bench) takes slave.
interface uart_rx_if;
    logic       rx;
    logic       rdy_clr;
    logic [7:0] rxdata;
    logic       rdy;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    modport master (input rx, rdy_clr, output rxdata, rdy, frame_err, overrun, busy);
    modport slave  (output rx, rdy_clr, input rxdata, rdy, frame_err, overrun, busy);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversampled, 3-sample majority per bit, start-glitch rejection,
// single-entry holding register with rdy/rdy_clr handshake and framing/overrun pulses.
module uart_rx #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic      clk,
    input  logic      reset,
    uart_rx_if.master bus
);
    localparam int DIV_RAW = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int S_W     = $clog2(OVERSAMPLE);
    localparam int M       = OVERSAMPLE / 2;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [S_W-1:0]   S_FIRST  = S_W'(M - 1);
    localparam logic [S_W-1:0]   S_MID    = S_W'(M);
    localparam logic [S_W-1:0]   S_DEC    = S_W'(M + 1);
    localparam logic [S_W-1:0]   S_LAST   = S_W'(OVERSAMPLE - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e           state_q, state_d;
    logic             rx_meta_q, rxs_q, rxs_prev_q;
    logic [DIV_W-1:0] div_q, div_d;
    logic [S_W-1:0]   s_q, s_d;
    logic [2:0]       bit_q, bit_d;
    logic [1:0]       samp_q, samp_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       rxdata_q, rxdata_d;
    logic             rdy_q, rdy_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;

    logic tick, maj, decide, bit_end;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path infers a latch.
        tick    = (div_q == DIV_LAST);
        maj     = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxs_q) | (samp_q[1] & rxs_q);
        decide  = tick && (s_q == S_DEC);
        bit_end = tick && (s_q == S_LAST);

        state_d     = state_q;
        div_d       = tick ? '0 : div_q + 1'b1;
        s_d         = tick ? (bit_end ? '0 : s_q + 1'b1) : s_q;
        bit_d       = bit_q;
        samp_d      = samp_q;
        shift_d     = shift_q;
        rxdata_d    = rxdata_q;
        rdy_d       = bus.rdy_clr ? 1'b0 : rdy_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;

        if (tick && s_q == S_FIRST) samp_d[0] = rxs_q;
        if (tick && s_q == S_MID)   samp_d[1] = rxs_q;

        case (state_q)
            IDLE: begin
                div_d = '0;
                s_d   = '0;
                if (rxs_prev_q && !rxs_q) state_d = START;
            end
            START: begin
                if (decide && maj) begin
                    state_d = IDLE;
                end else if (bit_end) begin
                    state_d = DATA;
                    bit_d   = 3'd0;
                end
            end
            DATA: begin
                if (decide) shift_d = {maj, shift_q[7:1]};
                if (bit_end) begin
                    if (bit_q == 3'd7) state_d = STOP;
                    bit_d = bit_q + 3'd1;
                end
            end
            STOP: begin
                // Leave at the decision point so an immediately following start bit is seen.
                if (decide) begin
                    state_d = IDLE;
                    if (maj) begin
                        rxdata_d  = shift_q;
                        rdy_d     = 1'b1;
                        overrun_d = rdy_q & ~bus.rdy_clr;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            rx_meta_q   <= 1'b1;
            rxs_q       <= 1'b1;
            rxs_prev_q  <= 1'b1;
            div_q       <= '0;
            s_q         <= '0;
            bit_q       <= '0;
            samp_q      <= '0;
            shift_q     <= '0;
            rxdata_q    <= '0;
            rdy_q       <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rx_meta_q   <= bus.rx;
            rxs_q       <= rx_meta_q;
            rxs_prev_q  <= rxs_q;
            div_q       <= div_d;
            s_q         <= s_d;
            bit_q       <= bit_d;
            samp_q      <= samp_d;
            shift_q     <= shift_d;
            rxdata_q    <= rxdata_d;
            rdy_q       <= rdy_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.rxdata    = rxdata_q;
    assign bus.rdy       = rdy_q;
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;
    assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed corner cases plus random 8N1 frames
// compared against a frame-level model of the holding register and error pulses.
module tb_uart_rx;
    localparam int CLK_HZ   = 3_200_000;
    localparam int BAUD     = 100_000;
    localparam int OS       = 16;
    localparam int BIT_CLKS = CLK_HZ / BAUD;
    localparam int LAT_MIN  = 304;
    localparam int LAT_MAX  = 316;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    uart_rx_if bus_if ();

    uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;
    int   fall_cyc = 0;
    int   evt_cyc  = -1;
    int   fe_cnt   = 0;
    int   ov_cnt   = 0;
    int   fe0, ov0, lat;
    logic busy_seen = 1'b0;
    logic rdy_prev  = 1'b0;

    // Frame-level reference model
    logic [7:0] exp_data = 8'h00;
    logic       exp_rdy  = 1'b0;
    int         exp_fe, exp_ov;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (bus_if.frame_err) fe_cnt++;
        if (bus_if.overrun)   ov_cnt++;
        if (bus_if.busy)      busy_seen = 1'b1;
        if (bus_if.rdy && !rdy_prev) evt_cyc = cyc;
        rdy_prev = bus_if.rdy;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drives start, 8 data bits LSB first and the stop bit; stops early after 'limit' clocks.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int limit);
        int         n;
        logic [9:0] bits;
        n    = 0;
        bits = {stop, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            bus_if.rx = bits[i];
            if (i == 0) fall_cyc = cyc;
            for (int k = 0; k < BIT_CLKS; k++) begin
                if (n == limit) return;
                @(negedge clk);
                n++;
            end
        end
    endtask

    task automatic check_state(input string tag);
        check($sformatf("%s.rxdata", tag), bus_if.rxdata, exp_data);
        check($sformatf("%s.rdy", tag), bus_if.rdy, exp_rdy);
        check($sformatf("%s.frame_err", tag), fe_cnt - fe0, exp_fe);
        check($sformatf("%s.overrun", tag), ov_cnt - ov0, exp_ov);
    endtask

    task automatic frame(input logic [7:0] d, input logic stop, input string tag);
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        if (stop) begin
            exp_ov   = exp_rdy ? 1 : 0;
            exp_fe   = 0;
            exp_rdy  = 1'b1;
            exp_data = d;
        end else begin
            exp_ov = 0;
            exp_fe = 1;
        end
        send_frame(d, stop, -1);
        check_state(tag);
        if (!stop) begin
            bus_if.rx = 1'b1;
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic clear_rdy();
        bus_if.rdy_clr = 1'b1;
        @(negedge clk);
        bus_if.rdy_clr = 1'b0;
        exp_rdy = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check($sformatf("%s.rxdata", tag), bus_if.rxdata, 8'h00);
        check($sformatf("%s.rdy", tag), bus_if.rdy, 1'b0);
        check($sformatf("%s.frame_err", tag), bus_if.frame_err, 1'b0);
        check($sformatf("%s.overrun", tag), bus_if.overrun, 1'b0);
        check($sformatf("%s.busy", tag), bus_if.busy, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus_if.rx      = 1'b1;
        bus_if.rdy_clr = 1'b0;

        // Reset held with a toggling line, then released on an idle line
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus_if.rx = 1'($urandom_range(0, 1));
        end
        check_zero("reset_hold");
        bus_if.rx = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (40) @(negedge clk);
        check_zero("reset_release");

        // Basic byte, latency and consumer clear
        frame(8'h61, 1'b1, "basic");
        lat = evt_cyc - fall_cyc;
        check("latency_in_window", (lat >= LAT_MIN && lat <= LAT_MAX), 1'b1);
        clear_rdy();
        check("clr.rdy", bus_if.rdy, 1'b0);
        check("clr.rxdata", bus_if.rxdata, 8'h61);

        // Start-bit glitch is rejected silently
        fe0 = fe_cnt;
        busy_seen = 1'b0;
        bus_if.rx = 1'b0;
        repeat (6) @(negedge clk);
        bus_if.rx = 1'b1;
        repeat (60) @(negedge clk);
        check("glitch.busy_seen", busy_seen, 1'b1);
        check("glitch.busy", bus_if.busy, 1'b0);
        check("glitch.rdy", bus_if.rdy, 1'b0);
        check("glitch.frame_err", fe_cnt - fe0, 0);
        frame(8'h55, 1'b1, "after_glitch");

        // Framing error leaves the holding register alone
        clear_rdy();
        frame(8'hA5, 1'b0, "framing");

        // Back-to-back bytes without clearing -> overrun on the second
        frame(8'h12, 1'b1, "ovr_first");
        frame(8'h34, 1'b1, "ovr_second");

        // Clear on the completion edge: set wins and no overrun
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        if (lat >= LAT_MIN && lat <= LAT_MAX) begin
            fork
                send_frame(8'h56, 1'b1, -1);
                begin
                    repeat (lat - 1) @(negedge clk);
                    bus_if.rdy_clr = 1'b1;
                    @(negedge clk);
                    bus_if.rdy_clr = 1'b0;
                end
            join
            exp_data = 8'h56;
            exp_rdy  = 1'b1;
            exp_fe   = 0;
            exp_ov   = 0;
            check_state("clr_on_done");
        end

        // Break: rx held low gives one framing error, then stays idle
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        bus_if.rx = 1'b0;
        repeat (11 * BIT_CLKS) @(negedge clk);
        exp_fe = 1;
        exp_ov = 0;
        check_state("break");
        check("break.busy", bus_if.busy, 1'b0);
        repeat (64) @(negedge clk);
        check("break_hold.busy", bus_if.busy, 1'b0);
        check("break_hold.frame_err", fe_cnt - fe0, 1);
        bus_if.rx = 1'b1;
        repeat (40) @(negedge clk);

        // Reset during bit 3 of 0xF0 aborts the frame
        send_frame(8'hF0, 1'b1, 4 * BIT_CLKS + 16);
        check("midreset.busy_before", bus_if.busy, 1'b1);
        #2 reset = 1'b0;
        #1 check_zero("midreset");
        exp_data = 8'h00;
        exp_rdy  = 1'b0;
        @(negedge clk);
        bus_if.rx = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        repeat (8) @(negedge clk);
        frame(8'h0F, 1'b1, "after_reset");

        // Random frames with random stop validity, gaps and clears
        for (int i = 0; i < 12; i++) begin
            logic [7:0] d;
            logic       stop;
            int         gap;
            d    = 8'($urandom);
            stop = ($urandom_range(0, 4) != 0);
            gap  = $urandom_range(0, 30);
            frame(d, stop, $sformatf("rand%0d", i));
            if (gap >= 2 && $urandom_range(0, 1) == 1) clear_rdy();
            repeat (gap) @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
